// File: rtl/soc_addr_map_cfg_pkg.sv
// Shared SoC address-map types: slave enum, rule struct, commit FSM states and the reset map.
package soc_addr_map_cfg_pkg;

  localparam int unsigned SocNumRules  = 14;
  localparam int unsigned SocAddrWidth = 64;
  localparam int unsigned SocIdxWidth  = 4;

  typedef enum logic [3:0] {
    SlvDebug = 4'd0,
    SlvRom   = 4'd1,
    SlvClint = 4'd2,
    SlvPlic  = 4'd3,
    SlvTimer = 4'd4,
    SlvL2spm = 4'd5,
    SlvUart  = 4'd6,
    SlvSpi   = 4'd7,
    SlvI2c   = 4'd8,
    SlvGpio  = 4'd9,
    SlvDma   = 4'd10,
    SlvEth   = 4'd11,
    SlvDram  = 4'd12,
    SlvHyaxi = 4'd13
  } slave_e;

  typedef struct packed {
    logic [SocIdxWidth-1:0]  idx;
    logic [SocAddrWidth-1:0] start_addr;
    logic [SocAddrWidth-1:0] length;
    logic                    valid;
  } rule_t;

  typedef enum logic [1:0] {
    CommitIdle  = 2'd0,
    CommitDrain = 2'd1,
    CommitCopy  = 2'd2
  } commit_state_e;

  function automatic rule_t soc_rule(slave_e slv, logic [63:0] base, logic [63:0] len);
    rule_t r;
    r.idx        = slv;
    r.start_addr = base;
    r.length     = len;
    r.valid      = 1'b1;
    return r;
  endfunction

  function automatic rule_t [SocNumRules-1:0] soc_rst_map();
    rule_t [SocNumRules-1:0] m;
    m[0]  = soc_rule(SlvDebug, 64'h0000_0000, 64'h0000_1000);
    m[1]  = soc_rule(SlvRom,   64'h0001_0000, 64'h0001_0000);
    m[2]  = soc_rule(SlvClint, 64'h0200_0000, 64'h0001_0000);
    m[3]  = soc_rule(SlvPlic,  64'h0C00_0000, 64'h0400_0000);
    m[4]  = soc_rule(SlvTimer, 64'h1800_0000, 64'h0000_1000);
    m[5]  = soc_rule(SlvL2spm, 64'h1C00_0000, 64'h0010_0000);
    m[6]  = soc_rule(SlvUart,  64'h2000_0000, 64'h0000_1000);
    m[7]  = soc_rule(SlvSpi,   64'h2000_1000, 64'h0000_1000);
    m[8]  = soc_rule(SlvI2c,   64'h2000_2000, 64'h0000_1000);
    m[9]  = soc_rule(SlvGpio,  64'h2000_3000, 64'h0000_1000);
    m[10] = soc_rule(SlvDma,   64'h2000_4000, 64'h0000_1000);
    m[11] = soc_rule(SlvEth,   64'h2000_8000, 64'h0000_8000);
    m[12] = soc_rule(SlvDram,  64'h4000_0000, 64'h1000_0000);
    m[13] = soc_rule(SlvHyaxi, 64'h8000_0000, 64'h2000_0000);
    return m;
  endfunction

  localparam rule_t [SocNumRules-1:0] SocRstMap = soc_rst_map();

endpackage

// File: rtl/addr_rule_match.sv
// Combinational priority matcher: lowest-numbered rule containing the address wins.
module addr_rule_match #(
  parameter int unsigned NumRules  = 14,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdxWidth  = 4
) (
  input  logic [AddrWidth-1:0]                addr_i,
  input  logic [NumRules-1:0][AddrWidth-1:0]  base_i,
  input  logic [NumRules-1:0][AddrWidth-1:0]  len_i,
  input  logic [NumRules-1:0][IdxWidth-1:0]   idx_i,
  input  logic [NumRules-1:0]                 valid_i,
  output logic                                hit_c,
  output logic [IdxWidth-1:0]                 idx_c
);

  logic [NumRules-1:0][AddrWidth:0] end_c;
  logic [NumRules-1:0]              match_c;

  // End address carries an extra bit so a rule reaching the top of space cannot wrap.
  always_comb begin
    end_c   = '0;
    match_c = '0;
    idx_c   = '0;
    for (int r = 0; r < int'(NumRules); r++) begin
      end_c[r]   = {1'b0, base_i[r]} + {1'b0, len_i[r]};
      match_c[r] = valid_i[r] && (len_i[r] != '0) && (addr_i >= base_i[r]) &&
                   ({1'b0, addr_i} < end_c[r]);
    end
    for (int r = int'(NumRules) - 1; r >= 0; r--) begin
      if (match_c[r]) idx_c = idx_i[r];
    end
  end

  assign hit_c = |match_c;

endmodule

// File: rtl/soc_addr_map_cfg.sv
// Double-banked SoC address decoder with shadow-write and drain-then-copy commit.
module soc_addr_map_cfg
  import soc_addr_map_cfg_pkg::*;
#(
  parameter int unsigned          NumRules   = SocNumRules,
  parameter int unsigned          AddrWidth  = 64,
  parameter int unsigned          IdxWidth   = 4,
  parameter int unsigned          DefaultIdx = 0,
  parameter rule_t [NumRules-1:0] RstMap     = SocRstMap,
  localparam int unsigned         RuleW      = (NumRules > 1) ? $clog2(NumRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic [RuleW-1:0]     cfg_rule_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [63:0]          cfg_wdata_i,
  input  logic                 cfg_commit_i,
  output logic                 cfg_busy_o,
  output logic                 cfg_done_o,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [IdxWidth-1:0]  resp_idx_o,
  output logic                 resp_err_o
);

  logic [NumRules-1:0][AddrWidth-1:0] sh_base_q, sh_base_d, sh_len_q, sh_len_d;
  logic [NumRules-1:0][AddrWidth-1:0] act_base_q, act_base_d, act_len_q, act_len_d;
  logic [NumRules-1:0][IdxWidth-1:0]  sh_idx_q, sh_idx_d, act_idx_q, act_idx_d;
  logic [NumRules-1:0]                sh_vld_q, sh_vld_d, act_vld_q, act_vld_d;

  commit_state_e         state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [IdxWidth-1:0]   resp_idx_q, resp_idx_d;
  logic                  resp_err_q, resp_err_d;

  logic                  hit_c;
  logic [IdxWidth-1:0]   hit_idx_c;
  logic                  req_fire_c;
  logic                  wr_legal_c;

  addr_rule_match #(
    .NumRules  (NumRules),
    .AddrWidth (AddrWidth),
    .IdxWidth  (IdxWidth)
  ) u_match (
    .addr_i  (req_addr_i),
    .base_i  (act_base_q),
    .len_i   (act_len_q),
    .idx_i   (act_idx_q),
    .valid_i (act_vld_q),
    .hit_c   (hit_c),
    .idx_c   (hit_idx_c)
  );

  assign req_ready_o = !busy_q && (!resp_valid_q || resp_ready_i);
  assign req_fire_c  = req_valid_i && req_ready_o;
  assign wr_legal_c  = (32'(cfg_rule_i) < NumRules) && (cfg_field_i != 2'd3) && !busy_q;

  // Next-state: shadow writes, commit FSM with bank copy, and the decode output stage.
  always_comb begin
    sh_base_d    = sh_base_q;
    sh_len_d     = sh_len_q;
    sh_idx_d     = sh_idx_q;
    sh_vld_d     = sh_vld_q;
    act_base_d   = act_base_q;
    act_len_d    = act_len_q;
    act_idx_d    = act_idx_q;
    act_vld_d    = act_vld_q;
    state_d      = state_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_idx_d   = resp_idx_q;
    resp_err_d   = resp_err_q;

    if (cfg_we_i) begin
      if (wr_legal_c) begin
        unique case (cfg_field_i)
          2'd0:    sh_base_d[cfg_rule_i] = AddrWidth'(cfg_wdata_i);
          2'd1:    sh_len_d[cfg_rule_i]  = AddrWidth'(cfg_wdata_i);
          2'd2: begin
            sh_idx_d[cfg_rule_i] = IdxWidth'(cfg_wdata_i);
            sh_vld_d[cfg_rule_i] = cfg_wdata_i[63];
          end
          default: ;
        endcase
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      CommitIdle:  if (cfg_commit_i) state_d = CommitDrain;
      CommitDrain: if (!resp_valid_q || resp_ready_i) state_d = CommitCopy;
      CommitCopy: begin
        act_base_d = sh_base_q;
        act_len_d  = sh_len_q;
        act_idx_d  = sh_idx_q;
        act_vld_d  = sh_vld_q;
        state_d    = CommitIdle;
        done_d     = 1'b1;
      end
      default:     state_d = CommitIdle;
    endcase
    busy_d = (state_d != CommitIdle);

    if (req_fire_c) begin
      resp_valid_d = 1'b1;
      resp_idx_d   = hit_c ? hit_idx_c : IdxWidth'(DefaultIdx);
      resp_err_d   = !hit_c;
    end else if (resp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < int'(NumRules); r++) begin
        sh_base_q[r]  <= AddrWidth'(RstMap[r].start_addr);
        sh_len_q[r]   <= AddrWidth'(RstMap[r].length);
        sh_idx_q[r]   <= IdxWidth'(RstMap[r].idx);
        sh_vld_q[r]   <= RstMap[r].valid;
        act_base_q[r] <= AddrWidth'(RstMap[r].start_addr);
        act_len_q[r]  <= AddrWidth'(RstMap[r].length);
        act_idx_q[r]  <= IdxWidth'(RstMap[r].idx);
        act_vld_q[r]  <= RstMap[r].valid;
      end
      state_q      <= CommitIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_idx_q   <= IdxWidth'(DefaultIdx);
      resp_err_q   <= 1'b0;
    end else begin
      sh_base_q    <= sh_base_d;
      sh_len_q     <= sh_len_d;
      sh_idx_q     <= sh_idx_d;
      sh_vld_q     <= sh_vld_d;
      act_base_q   <= act_base_d;
      act_len_q    <= act_len_d;
      act_idx_q    <= act_idx_d;
      act_vld_q    <= act_vld_d;
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_idx_q   <= resp_idx_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign cfg_busy_o   = busy_q;
  assign cfg_done_o   = done_q;
  assign cfg_err_o    = err_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_idx_o   = resp_idx_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_soc_addr_map_cfg.sv
// Directed bench for soc_addr_map_cfg: reset map, misses, overlap, top of space, commit and error paths.
module tb_soc_addr_map_cfg;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cfg_we_i;
  logic [3:0]  cfg_rule_i;
  logic [1:0]  cfg_field_i;
  logic [63:0] cfg_wdata_i;
  logic        cfg_commit_i;
  logic        cfg_busy_o, cfg_done_o, cfg_err_o;
  logic        req_valid_i, req_ready_o;
  logic [63:0] req_addr_i;
  logic        resp_valid_o, resp_ready_i;
  logic [3:0]  resp_idx_o;
  logic        resp_err_o;

  int checks = 0;
  int errors = 0;

  soc_addr_map_cfg dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_we_i     (cfg_we_i),
    .cfg_rule_i   (cfg_rule_i),
    .cfg_field_i  (cfg_field_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_commit_i (cfg_commit_i),
    .cfg_busy_o   (cfg_busy_o),
    .cfg_done_o   (cfg_done_o),
    .cfg_err_o    (cfg_err_o),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_idx_o   (resp_idx_o),
    .resp_err_o   (resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] rule, input logic [1:0] field,
                           input logic [63:0] data, input logic exp_err, input string tag);
    cfg_we_i    = 1'b1;
    cfg_rule_i  = rule;
    cfg_field_i = field;
    cfg_wdata_i = data;
    tick();
    cfg_we_i = 1'b0;
    check(tag, 64'(cfg_err_o), 64'(exp_err));
  endtask

  // Response word checked as {valid, err, idx}.
  task automatic decode(input logic [63:0] addr, input logic [3:0] exp_idx,
                        input logic exp_err, input string tag);
    req_valid_i  = 1'b1;
    req_addr_i   = addr;
    resp_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    check(tag, 64'({resp_valid_o, resp_err_o, resp_idx_o}), 64'({1'b1, exp_err, exp_idx}));
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (cfg_done_o) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic commit_and_wait(input string tag);
    cfg_commit_i = 1'b1;
    tick();
    cfg_commit_i = 1'b0;
    check({tag, "_busy"}, 64'(cfg_busy_o), 64'd1);
    wait_done({tag, "_done"});
  endtask

  initial begin
    rst_ni       = 1'b0;
    cfg_we_i     = 1'b0;
    cfg_rule_i   = '0;
    cfg_field_i  = '0;
    cfg_wdata_i  = '0;
    cfg_commit_i = 1'b0;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    resp_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs",
          64'({resp_valid_o, cfg_busy_o, cfg_done_o, cfg_err_o, resp_err_o, resp_idx_o}), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check("ready_after_reset", 64'(req_ready_o), 64'd1);

    // Reset map
    decode(64'h1C00_0100, 4'd5, 1'b0, "rst_l2spm");
    decode(64'h8000_0000, 4'd13, 1'b0, "rst_hyaxi");
    decode(64'h5000_0000, 4'd0, 1'b1, "rst_miss");
    decode(64'h4FFF_FFFF, 4'd12, 1'b0, "rst_dram_last");

    // Overlap: rule 2 and rule 7 both cover 0x1880, rule 2 must win
    cfg_write(4'd2, 2'd0, 64'h1000, 1'b0, "wr_r2_base");
    cfg_write(4'd2, 2'd1, 64'h1000, 1'b0, "wr_r2_len");
    cfg_write(4'd2, 2'd2, 64'h8000_0000_0000_000A, 1'b0, "wr_r2_idx");
    cfg_write(4'd7, 2'd0, 64'h1800, 1'b0, "wr_r7_base");
    cfg_write(4'd7, 2'd1, 64'h0100, 1'b0, "wr_r7_len");
    decode(64'h1880, 4'd0, 1'b1, "shadow_not_used");
    cfg_we_i     = 1'b1;
    cfg_rule_i   = 4'd7;
    cfg_field_i  = 2'd2;
    cfg_wdata_i  = 64'h8000_0000_0000_0007;
    cfg_commit_i = 1'b1;
    tick();
    cfg_we_i     = 1'b0;
    cfg_commit_i = 1'b0;
    check("wr_commit_same_cycle", 64'({cfg_err_o, cfg_busy_o}), 64'b01);
    wait_done("overlap_done");
    decode(64'h1880, 4'hA, 1'b0, "overlap_low_wins");
    decode(64'h1FFF, 4'hA, 1'b0, "r2_last");
    decode(64'h2000, 4'd0, 1'b1, "r2_end_excl");
    decode(64'h0200_0000, 4'd0, 1'b1, "clint_moved");

    // Top of address space, with rule 0 disabled so address 0 misses entirely
    cfg_write(4'd3, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 1'b0, "wr_r3_base");
    cfg_write(4'd3, 2'd1, 64'h2000, 1'b0, "wr_r3_len");
    cfg_write(4'd3, 2'd2, 64'h8000_0000_0000_0009, 1'b0, "wr_r3_idx");
    cfg_write(4'd0, 2'd2, 64'h0, 1'b0, "wr_r0_invalid");
    commit_and_wait("top");
    decode(64'hFFFF_FFFF_FFFF_FFF8, 4'd9, 1'b0, "top_hit");
    decode(64'h0, 4'd0, 1'b1, "top_no_wrap");

    // Illegal writes
    cfg_write(4'd14, 2'd2, 64'h8000_0000_0000_0003, 1'b1, "wr_rule14_err");
    tick();
    check("err_single_pulse", 64'(cfg_err_o), 64'd0);
    cfg_write(4'd1, 2'd3, 64'h0, 1'b1, "wr_field3_err");
    commit_and_wait("illegal");
    decode(64'h1880, 4'hA, 1'b0, "illegal_map_same");
    decode(64'h0001_0000, 4'd1, 1'b0, "illegal_rom_same");

    // Commit under backpressure
    cfg_write(4'd2, 2'd2, 64'h8000_0000_0000_000B, 1'b0, "wr_r2_idxB");
    req_valid_i  = 1'b1;
    req_addr_i   = 64'h1880;
    resp_ready_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    check("bp_resp", 64'({resp_valid_o, resp_err_o, resp_idx_o}), 64'({1'b1, 1'b0, 4'hA}));
    check("bp_not_ready", 64'(req_ready_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", 64'({resp_valid_o, resp_err_o, resp_idx_o}), 64'({1'b1, 1'b0, 4'hA}));
    end
    cfg_commit_i = 1'b1;
    tick();
    cfg_commit_i = 1'b0;
    check("bp_busy", 64'(cfg_busy_o), 64'd1);
    cfg_write(4'd2, 2'd2, 64'h8000_0000_0000_000C, 1'b1, "wr_drain_err");
    tick();
    check("bp_drain_hold",
          64'({cfg_busy_o, cfg_done_o, resp_valid_o, resp_err_o, resp_idx_o}),
          64'({1'b1, 1'b0, 1'b1, 1'b0, 4'hA}));
    resp_ready_i = 1'b1;
    tick();
    check("bp_copy", 64'({cfg_busy_o, cfg_done_o, resp_valid_o}), 64'b100);
    tick();
    check("bp_done", 64'({cfg_busy_o, cfg_done_o}), 64'b01);
    tick();
    check("bp_done_clr", 64'(cfg_done_o), 64'd0);
    decode(64'h1880, 4'hB, 1'b0, "bp_new_map");

    // Reset while in COPY
    cfg_commit_i = 1'b1;
    tick();
    cfg_commit_i = 1'b0;
    tick();
    check("copy_busy", 64'(cfg_busy_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_in_copy",
          64'({cfg_busy_o, cfg_done_o, resp_valid_o, cfg_err_o}), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check("ready_after_rst2", 64'(req_ready_o), 64'd1);
    decode(64'h1C00_0100, 4'd5, 1'b0, "rst2_l2spm");
    decode(64'h1880, 4'd0, 1'b1, "rst2_no_overlap");
    decode(64'hFFFF_FFFF_FFFF_FFF8, 4'd0, 1'b1, "rst2_no_top");
    decode(64'h0, 4'd0, 1'b0, "rst2_debug");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
